serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
Sequencer for the bit-serial adder datapath. It accepts one operand pair per transaction over a valid/ready handshake and feeds the pair to an external one-bit full adder, LSB first, one bit per clock. It keeps the carry flip-flop and collects the sum bits, then presents the WIDTH-bit sum and carry-out through a valid/ready handshake. It sits between the operand source and the result consumer, and owns the timing of the full-adder cell.

Parameters:
WIDTH, 4, operand and sum width in bits; legal range is 2 or more.

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset; asserted when 0.
in_valid  input  1  operand pair a, b, cin is valid.
in_ready  output  1  controller can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  initial carry.
fa_a  output  1  A bit to the full adder.
fa_b  output  1  B bit to the full adder.
fa_c  output  1  carry bit to the full adder.
fa_sum  input  1  sum bit returned by the full adder (combinational).
fa_cout  input  1  carry bit returned by the full adder (combinational).
out_valid  output  1  sum and cout are valid.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  result sum.
cout  output  1  final carry-out.
busy  output  1  high in SHIFT or DONE.
bit_idx  output  $clog2(WIDTH)  index of the bit currently being processed.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE.
  - All shift registers, the carry register and bit_idx are 0.
  - Outputs: in_ready=1, out_valid=0, sum=0, cout=0, busy=0, fa_a/fa_b/fa_c=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: a_sh<=a, b_sh<=b, carry_q<=cin, sum_sh<=0, bit_idx<=0, then go to SHIFT.
- SHIFT:
  - in_ready=0; in_valid is ignored.
  - fa_a=a_sh[0], fa_b=b_sh[0], fa_c=carry_q. These are driven combinationally from registers.
  - Each edge:
    - sum_sh<={fa_sum, sum_sh[WIDTH-1:1]}.
    - carry_q<=fa_cout.
    - a_sh and b_sh shift right with 0 fill.
    - bit_idx<=bit_idx+1.
  - On the edge where bit_idx==WIDTH-1: go to DONE and clear bit_idx to 0.
- DONE:
  - out_valid=1, sum=sum_sh, cout=carry_q.
  - Hold sum and cout stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE.
  - in_ready=0 throughout DONE; a new transaction is never accepted on the result-handshake edge.
- fa_a, fa_b and fa_c are 0 in every state except SHIFT.
- Latency:
  - The accept edge is edge 0; out_valid rises after edge WIDTH.
  - Minimum spacing between accepts is WIDTH+2 edges.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). With a=all-ones, b=all-ones, cin=1 the result is sum=all-ones, cout=1.
- Source rule: the source holds a, b and cin stable until the handshake completes. The controller samples them only on the accept edge.
- Reset mid-operation: abort immediately to the reset values. No partial result is emitted.

Optional Feature:
SERIAL_ADD_SUB_EN
- Defined:
  - Adds input port sub (1 bit), captured on the accept edge.
  - When sub=1, b is captured inverted and carry_q is initialised to 1 (cin is ignored).
  - The result is a-b mod 2^WIDTH; cout=1 means no borrow.
  - When sub=0, behaviour is identical to add mode.
- Undefined: no sub port; add only.

Decomposition:
- Package serial_add_pkg:
  - state typedef enum {IDLE, SHIFT, DONE}.
  - Constant SA_WIDTH_DEFAULT=4.
  - Function computing the bit_idx width.
- Sub-module sa_shift_reg:
  - Parameterised WIDTH right-shift register with load, shift_en, serial_in, parallel_out, and async active-low reset.
  - Instantiated for a_sh, b_sh and sum_sh.
- The full-adder cell stays outside this block.

Test Plan:
The bench models the full adder combinationally; WIDTH=4.
1. a=4'h3, b=4'h5, cin=0 -> sum=4'h8, cout=0; fa_a sequence 1,1,0,0; fa_b sequence 1,0,1,0; out_valid exactly 4 edges after accept.
2. a=4'hF, b=4'h1, cin=0 -> sum=4'h0, cout=1 (wrap); a=4'hF, b=4'hF, cin=1 -> sum=4'hF, cout=1.
3. Hold out_ready=0 for 3 cycles in DONE, with in_valid=1 and a new pair a=4'h2, b=4'h2 -> out_valid, sum and cout stable; in_ready=0 throughout. After the out handshake, IDLE accepts the new pair and the result is sum=4'h4, cout=0.
4. Drive reset=0 while bit_idx==2 in SHIFT -> all outputs go to 0 and in_ready=1 immediately. After release, a=4'h6, b=4'h7, cin=1 -> sum=4'hE, cout=0.
5. Random sweep of 200 transactions with random in_valid/out_ready gaps -> every {cout,sum} equals a+b+cin; no dropped or duplicated results.
6. With SERIAL_ADD_SUB_EN: a=5, b=3, sub=1 -> sum=4'h2, cout=1; a=3, b=5, sub=1 -> sum=4'hE, cout=0.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_e;

  localparam int SA_WIDTH_DEFAULT = 4;

  // Width of the bit index counter; never narrower than one bit.
  function automatic int sa_idx_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/sa_shift_reg.sv
// Right-shift register with parallel load; load takes priority over shift.
module sa_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] parallel_out
);

  logic [WIDTH-1:0] q_r;

  // Shift register storage: load, shift right with serial_in at the MSB, or hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r <= {WIDTH{1'b0}};
    end else if (load) begin
      q_r <= load_val;
    end else if (shift_en) begin
      q_r <= {serial_in, q_r[WIDTH-1:1]};
    end else begin
      q_r <= q_r;
    end
  end

  assign parallel_out = q_r;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer driving an external full-adder cell, LSB first.
// Optional subtract mode (sub port) is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter  int WIDTH = SA_WIDTH_DEFAULT,
  localparam int IDX_W = sa_idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic [IDX_W-1:0] bit_idx
);

  sa_state_e        state_r;
  sa_state_e        next_state_s;
  logic             carry_r;
  logic [IDX_W-1:0] bit_idx_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic             load_s;
  logic             shift_s;
  logic             last_bit_s;
  logic [WIDTH-1:0] b_load_s;
  logic             carry_init_s;
  logic             unused_s;

  assign load_s     = (state_r == IDLE) && in_valid;
  assign shift_s    = (state_r == SHIFT);
  assign last_bit_s = (bit_idx_r == IDX_W'(WIDTH - 1));

`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1; cin is ignored in that mode.
  assign b_load_s     = sub ? ~b : b;
  assign carry_init_s = sub ? 1'b1 : cin;
`else
  assign b_load_s     = b;
  assign carry_init_s = cin;
`endif

  // Only bit 0 of the operand shifters feeds the adder.
  assign unused_s = ^{a_sh_r[WIDTH-1:1], b_sh_r[WIDTH-1:1]};

  sa_shift_reg #(.WIDTH(WIDTH)) u_a_sh (
    .clk         (clk),
    .reset       (reset),
    .load        (load_s),
    .load_val    (a),
    .shift_en    (shift_s),
    .serial_in   (1'b0),
    .parallel_out(a_sh_r)
  );

  sa_shift_reg #(.WIDTH(WIDTH)) u_b_sh (
    .clk         (clk),
    .reset       (reset),
    .load        (load_s),
    .load_val    (b_load_s),
    .shift_en    (shift_s),
    .serial_in   (1'b0),
    .parallel_out(b_sh_r)
  );

  sa_shift_reg #(.WIDTH(WIDTH)) u_sum_sh (
    .clk         (clk),
    .reset       (reset),
    .load        (load_s),
    .load_val    ({WIDTH{1'b0}}),
    .shift_en    (shift_s),
    .serial_in   (fa_sum),
    .parallel_out(sum_sh_r)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (in_valid)   next_state_s = SHIFT; else next_state_s = IDLE;
      SHIFT:   if (last_bit_s) next_state_s = DONE;  else next_state_s = SHIFT;
      DONE:    if (out_ready)  next_state_s = IDLE;  else next_state_s = DONE;
      default: next_state_s = IDLE;
    endcase
  end

  // Carry flip-flop and bit counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carry_r   <= 1'b0;
      bit_idx_r <= {IDX_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            carry_r   <= carry_init_s;
            bit_idx_r <= {IDX_W{1'b0}};
          end else begin
            carry_r   <= carry_r;
            bit_idx_r <= bit_idx_r;
          end
        end
        SHIFT: begin
          carry_r <= fa_cout;
          if (last_bit_s) begin
            bit_idx_r <= {IDX_W{1'b0}};
          end else begin
            bit_idx_r <= bit_idx_r + IDX_W'(1'b1);
          end
        end
        DONE: begin
          carry_r   <= carry_r;
          bit_idx_r <= bit_idx_r;
        end
        default: begin
          carry_r   <= 1'b0;
          bit_idx_r <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

  // Output decode; everything is a function of registered state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    fa_a      = 1'b0;
    fa_b      = 1'b0;
    fa_c      = 1'b0;
    sum       = {WIDTH{1'b0}};
    cout      = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = 1'b1;
      end
      SHIFT: begin
        busy = 1'b1;
        fa_a = a_sh_r[0];
        fa_b = b_sh_r[0];
        fa_c = carry_r;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        sum       = sum_sh_r;
        cout      = carry_r;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign bit_idx = bit_idx_r;

endmodule
